ram16x8_arbiter: RTL and testbench

- Round-robin arbiter and sequencer sharing one single-port 16x8 synchronous RAM between N_REQ requesters.
- Converts per-requester valid/ready read/write commands into the RAM's cs/w_en/op_en strobe protocol.
- Captures registered read data and returns it to the issuing requester with a held response handshake.
- Optional post-reset sweep zeroes all 16 words, because the RAM's own reset clears only the currently addressed word.

---
 rtl/ram16x8_arbiter.sv | 186 ++++++++++++++++++
 tb/tb_ram16x8_arbiter.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/ram16x8_arbiter.sv
// ram16x8_arbiter
//   Shares one single-port synchronous RAM (16x8 by default) between N_REQ
//   requesters. Commands are taken one at a time in round-robin order and
//   turned into the RAM's cs/w_en/op_en strobe protocol. Read data is
//   registered and returned to the issuing requester, held until accepted.
//   An optional sweep after reset writes zero to every word, because the
//   RAM's own reset clears only the word currently addressed.
//
// Ports
//   clk_i        system clock, all logic on the rising edge
//   reset_i      synchronous, active-high reset
//   req_valid_i  per-requester command valid
//   req_we_i     per-requester 1 = write, 0 = read
//   req_addr_i   packed addresses, requester i at [i*ADDR_W +: ADDR_W]
//   req_wdata_i  packed write data, requester i at [i*DATA_W +: DATA_W]
//   req_ready_o  one-hot accept strobe (combinational, IDLE only)
//   rsp_valid_o  one-hot read response valid (registered)
//   rsp_ready_i  per-requester response accept
//   rsp_data_o   shared read data, qualified by any rsp_valid_o bit
//   ram_*_o      registered RAM strobes, address and write data
//   ram_dout_i   RAM registered read data
//   init_done_o  high once the controller accepts requests
//   busy_o       high in every state except IDLE
module ram16x8_arbiter #(
  parameter int N_REQ      = 2,
  parameter int ADDR_W     = 4,
  parameter int DATA_W     = 8,
  parameter bit INIT_CLEAR = 1'b1
) (
  input  logic                    clk_i,
  input  logic                    reset_i,
  input  logic [N_REQ-1:0]        req_valid_i,
  input  logic [N_REQ-1:0]        req_we_i,
  input  logic [N_REQ*ADDR_W-1:0] req_addr_i,
  input  logic [N_REQ*DATA_W-1:0] req_wdata_i,
  output logic [N_REQ-1:0]        req_ready_o,
  output logic [N_REQ-1:0]        rsp_valid_o,
  input  logic [N_REQ-1:0]        rsp_ready_i,
  output logic [DATA_W-1:0]       rsp_data_o,
  output logic                    ram_cs_o,
  output logic                    ram_w_en_o,
  output logic                    ram_op_en_o,
  output logic [ADDR_W-1:0]       ram_addr_o,
  output logic [DATA_W-1:0]       ram_din_o,
  input  logic [DATA_W-1:0]       ram_dout_i,
  output logic                    init_done_o,
  output logic                    busy_o
);

  localparam int GW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  typedef enum logic [2:0] {
    S_INIT,
    S_IDLE,
    S_CMD,
    S_RD_CAP,
    S_RSP
  } state_t;

  state_t              state_q;
  logic                ram_cs_q;
  logic                ram_w_en_q;
  logic                ram_op_en_q;
  logic [ADDR_W-1:0]   ram_addr_q;
  logic [DATA_W-1:0]   ram_din_q;
  logic [DATA_W-1:0]   rsp_data_q;
  logic [N_REQ-1:0]    rsp_valid_q;
  logic                init_done_q;
  logic [GW-1:0]       last_grant_q;
  logic [GW-1:0]       owner_q;

  logic                grant_valid_d;
  logic [GW-1:0]       grant_idx_d;

  // Unpacked views of the per-requester command fields.
  logic [ADDR_W-1:0]   addr_arr [N_REQ];
  logic [DATA_W-1:0]   wdata_arr [N_REQ];

  for (genvar gi = 0; gi < N_REQ; gi++) begin : g_unpack
    assign addr_arr[gi]  = req_addr_i[gi*ADDR_W +: ADDR_W];
    assign wdata_arr[gi] = req_wdata_i[gi*DATA_W +: DATA_W];
  end

  // Round robin: candidates are visited from farthest to nearest after the
  // last grant, so the nearest valid requester is the one left standing.
  always_comb begin
    int      idx;
    logic [GW-1:0] cand;
    grant_valid_d = 1'b0;
    grant_idx_d   = '0;
    idx           = 0;
    cand          = '0;
    for (int k = N_REQ; k >= 1; k--) begin
      idx = int'(last_grant_q) + k;
      if (idx >= N_REQ) idx = idx - N_REQ;
      cand = GW'(idx);
      if (req_valid_i[cand]) begin
        grant_valid_d = 1'b1;
        grant_idx_d   = cand;
      end
    end
  end

  assign req_ready_o = (state_q == S_IDLE && grant_valid_d) ?
                       (N_REQ'(1) << grant_idx_d) : '0;

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q      <= INIT_CLEAR ? S_INIT : S_IDLE;
      ram_cs_q     <= 1'b0;
      ram_w_en_q   <= 1'b0;
      ram_op_en_q  <= 1'b0;
      ram_addr_q   <= '0;
      ram_din_q    <= '0;
      rsp_data_q   <= '0;
      rsp_valid_q  <= '0;
      init_done_q  <= 1'b0;
      // Pointing at the last requester makes requester 0 first in line.
      last_grant_q <= GW'(N_REQ - 1);
      owner_q      <= '0;
    end else begin
      case (state_q)
        S_INIT: begin
          // The first INIT cycle only raises the strobes; ram_addr_q then
          // doubles as the sweep counter.
          if (!ram_cs_q) begin
            ram_cs_q    <= 1'b1;
            ram_w_en_q  <= 1'b1;
            ram_op_en_q <= 1'b0;
            ram_addr_q  <= '0;
            ram_din_q   <= '0;
          end else if (ram_addr_q == '1) begin
            ram_cs_q    <= 1'b0;
            ram_w_en_q  <= 1'b0;
            init_done_q <= 1'b1;
            state_q     <= S_IDLE;
          end else begin
            ram_addr_q <= ram_addr_q + 1'b1;
          end
        end
        S_IDLE: begin
          init_done_q <= 1'b1;
          if (grant_valid_d) begin
            ram_cs_q     <= 1'b1;
            ram_w_en_q   <= req_we_i[grant_idx_d];
            ram_op_en_q  <= ~req_we_i[grant_idx_d];
            ram_addr_q   <= addr_arr[grant_idx_d];
            ram_din_q    <= wdata_arr[grant_idx_d];
            owner_q      <= grant_idx_d;
            last_grant_q <= grant_idx_d;
            state_q      <= S_CMD;
          end
        end
        S_CMD: begin
          ram_cs_q    <= 1'b0;
          ram_w_en_q  <= 1'b0;
          ram_op_en_q <= 1'b0;
          state_q     <= ram_w_en_q ? S_IDLE : S_RD_CAP;
        end
        S_RD_CAP: begin
          rsp_data_q  <= ram_dout_i;
          rsp_valid_q <= N_REQ'(1) << owner_q;
          state_q     <= S_RSP;
        end
        S_RSP: begin
          if (rsp_ready_i[owner_q]) begin
            rsp_valid_q <= '0;
            state_q     <= S_IDLE;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign rsp_valid_o = rsp_valid_q;
  assign rsp_data_o  = rsp_data_q;
  assign ram_cs_o    = ram_cs_q;
  assign ram_w_en_o  = ram_w_en_q;
  assign ram_op_en_o = ram_op_en_q;
  assign ram_addr_o  = ram_addr_q;
  assign ram_din_o   = ram_din_q;
  assign init_done_o = init_done_q;
  assign busy_o      = (state_q != S_IDLE);

endmodule

// File: tb/tb_ram16x8_arbiter.sv
// Directed testbench for ram16x8_arbiter with a behavioural 16x8 RAM model.
module tb_ram16x8_arbiter;

  logic        clk;
  logic        reset;
  logic [1:0]  req_valid;
  logic [1:0]  req_we;
  logic [7:0]  req_addr;
  logic [15:0] req_wdata;
  logic [1:0]  req_ready;
  logic [1:0]  rsp_valid;
  logic [1:0]  rsp_ready;
  logic [7:0]  rsp_data;
  logic        ram_cs;
  logic        ram_w_en;
  logic        ram_op_en;
  logic [3:0]  ram_addr;
  logic [7:0]  ram_din;
  logic [7:0]  ram_dout;
  logic        init_done;
  logic        busy;

  int n_cmp = 0;
  int n_err = 0;
  int last_wait = 0;

  ram16x8_arbiter #(.N_REQ(2), .ADDR_W(4), .DATA_W(8), .INIT_CLEAR(1'b1)) dut (
    .clk_i       (clk),
    .reset_i     (reset),
    .req_valid_i (req_valid),
    .req_we_i    (req_we),
    .req_addr_i  (req_addr),
    .req_wdata_i (req_wdata),
    .req_ready_o (req_ready),
    .rsp_valid_o (rsp_valid),
    .rsp_ready_i (rsp_ready),
    .rsp_data_o  (rsp_data),
    .ram_cs_o    (ram_cs),
    .ram_w_en_o  (ram_w_en),
    .ram_op_en_o (ram_op_en),
    .ram_addr_o  (ram_addr),
    .ram_din_o   (ram_din),
    .ram_dout_i  (ram_dout),
    .init_done_o (init_done),
    .busy_o      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Single-port synchronous RAM: write when cs&w_en, registered read when cs&op_en.
  logic [7:0] mem [16];
  initial ram_dout = 8'h00;
  always @(posedge clk) begin
    if (ram_cs) begin
      if (ram_w_en) mem[ram_addr] <= ram_din;
      else if (ram_op_en) ram_dout <= mem[ram_addr];
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: observed no finish, required finish before timeout");
    $fatal(1, "watchdog expired");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic wait_ready(input int r, input string tag);
    last_wait = 0;
    #1;
    while (req_ready[r] !== 1'b1 && last_wait < 20) begin
      tick();
      last_wait++;
    end
    chk({tag, "_ready"}, 32'(req_ready), 32'(1 << r));
  endtask

  task automatic do_write(input int r, input logic [3:0] a, input logic [7:0] d, input string tag);
    req_valid[r] = 1'b1;
    req_we[r] = 1'b1;
    req_addr[r*4 +: 4] = a;
    req_wdata[r*8 +: 8] = d;
    wait_ready(r, tag);
    tick();
    req_valid[r] = 1'b0;
    chk({tag, "_cs"}, 32'(ram_cs), 32'd1);
    chk({tag, "_wen"}, 32'({ram_w_en, ram_op_en}), 32'b10);
    chk({tag, "_addr"}, 32'(ram_addr), 32'(a));
    chk({tag, "_din"}, 32'(ram_din), 32'(d));
    tick();
    chk({tag, "_idle"}, 32'(busy), 32'd0);
    $display("write req%0d addr %0h data %02h", r, a, d);
  endtask

  task automatic do_read(input int r, input logic [3:0] a, input logic [7:0] exp, input string tag);
    req_valid[r] = 1'b1;
    req_we[r] = 1'b0;
    req_addr[r*4 +: 4] = a;
    wait_ready(r, tag);
    tick();
    req_valid[r] = 1'b0;
    chk({tag, "_cmd"}, 32'({ram_cs, ram_w_en, ram_op_en}), 32'b101);
    chk({tag, "_addr"}, 32'(ram_addr), 32'(a));
    tick();
    chk({tag, "_rdcap"}, 32'({rsp_valid, ram_cs}), 32'd0);
    tick();
    chk({tag, "_rspv"}, 32'(rsp_valid), 32'(1 << r));
    chk({tag, "_data"}, 32'(rsp_data), 32'(exp));
    $display("read  req%0d addr %0h data %02h", r, a, rsp_data);
    rsp_ready[r] = 1'b1;
    tick();
    rsp_ready[r] = 1'b0;
    chk({tag, "_done"}, 32'({rsp_valid, busy}), 32'd0);
  endtask

  initial begin
    int n;
    reset = 1'b1;
    req_valid = 2'b11;
    req_we = 2'b00;
    req_addr = 8'h00;
    req_wdata = 16'h0000;
    rsp_ready = 2'b00;

    // Reset state
    repeat (3) tick();
    chk("rst_strobes", 32'({ram_cs, ram_w_en, ram_op_en}), 32'd0);
    chk("rst_addr_din", 32'({ram_addr, ram_din}), 32'd0);
    chk("rst_flags", 32'({init_done, rsp_valid, req_ready}), 32'd0);
    chk("rst_busy", 32'(busy), 32'd1);
    $display("reset applied");

    // Zero-fill sweep; requester 0 waits with a read of addr 5
    req_valid = 2'b01;
    req_addr = 8'h05;
    reset = 1'b0;
    tick();
    for (int i = 0; i < 16; i++) begin
      chk("init_strobe", 32'({ram_cs, ram_w_en, ram_op_en, ram_din}), 32'h600);
      chk("init_addr", 32'(ram_addr), 32'(i));
      chk("init_noready", 32'({req_ready, init_done}), 32'd0);
      tick();
    end
    chk("init_done", 32'({init_done, ram_cs, busy}), 32'b100);
    $display("init sweep complete");
    do_read(0, 4'h5, 8'h00, "init_rd5");

    // Write then read back from the same requester
    do_write(0, 4'h3, 8'hA5, "wr3");
    do_read(0, 4'h3, 8'hA5, "rd3");

    // Fairness with both requesters continuously valid
    do_write(0, 4'h1, 8'h11, "pre1");
    do_write(1, 4'h2, 8'h22, "pre2");
    req_we = 2'b00;
    req_addr = {4'h2, 4'h1};
    req_valid = 2'b11;
    rsp_ready = 2'b11;
    #1;
    for (int k = 0; k < 4; k++) begin
      chk("rr_grant", 32'(req_ready), 32'(1 << (k % 2)));
      tick();
      tick();
      chk("rr_lat", 32'(rsp_valid), 32'd0);
      tick();
      chk("rr_rspv", 32'(rsp_valid), 32'(1 << (k % 2)));
      chk("rr_data", 32'(rsp_data), (k % 2 == 0) ? 32'h11 : 32'h22);
      $display("read  req%0d addr %0h data %02h", k % 2, (k % 2 == 0) ? 1 : 2, rsp_data);
      tick();
    end
    req_valid = 2'b00;
    rsp_ready = 2'b00;

    // Held response with back-pressure; requester 0 waiting meanwhile
    do_write(1, 4'hF, 8'hFF, "pre15");
    req_valid[1] = 1'b1;
    req_we[1] = 1'b0;
    req_addr[7:4] = 4'hF;
    wait_ready(1, "hold_rd15");
    tick();
    req_valid[1] = 1'b0;
    req_valid[0] = 1'b1;
    req_we[0] = 1'b0;
    req_addr[3:0] = 4'h5;
    tick();
    tick();
    for (int i = 0; i < 5; i++) begin
      chk("hold_rspv", 32'(rsp_valid), 32'b10);
      chk("hold_data", 32'(rsp_data), 32'hFF);
      chk("hold_noready", 32'(req_ready), 32'd0);
      rsp_ready = 2'b01;
      tick();
    end
    $display("read  req1 addr f data %02h (held)", rsp_data);
    rsp_ready = 2'b10;
    #1;
    chk("hold_hs_noready", 32'(req_ready), 32'd0);
    tick();
    rsp_ready = 2'b00;
    chk("hold_cleared", 32'(rsp_valid), 32'd0);
    chk("hold_next_ready", 32'(req_ready), 32'b01);
    do_read(0, 4'h5, 8'h00, "after_hold");

    // Write then immediate read from the other requester
    do_write(0, 4'h0, 8'h3C, "wr0");
    do_read(1, 4'h0, 8'h3C, "rd0_new");
    chk("rd0_no_wait", 32'(last_wait), 32'd0);

    // Reset during RD_CAP
    req_valid[0] = 1'b1;
    req_we[0] = 1'b0;
    req_addr[3:0] = 4'h3;
    wait_ready(0, "rst_mid");
    tick();
    req_valid[0] = 1'b0;
    tick();
    reset = 1'b1;
    tick();
    chk("rstmid_out", 32'({rsp_valid, ram_cs, init_done}), 32'd0);
    chk("rstmid_busy", 32'(busy), 32'd1);
    reset = 1'b0;
    $display("reset during RD_CAP");
    n = 0;
    while (init_done !== 1'b1 && n < 40) begin
      tick();
      n++;
    end
    chk("rstmid_init_done", 32'(init_done), 32'd1);

    // Pointer restored: requester 0 wins contention after reset
    req_we = 2'b00;
    req_addr = {4'h2, 4'h3};
    req_valid = 2'b11;
    do_read(0, 4'h3, 8'h00, "post_rst_r0");
    chk("post_rst_first", 32'(last_wait), 32'd0);
    do_read(1, 4'h2, 8'h00, "post_rst_r1");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
